// File: rtl/neuron_sram.sv
// Neuron-state SRAM responder: fixed-latency reads, potential-only writebacks and full-entry config writes.
// Optional macro NEURON_SRAM_WR_FWD_EN forwards a same-edge write into the read data register.
package data_types;
  localparam int SRAM_ADDR_SIZE = 8;
  localparam int V_PRECISION    = 16;
  localparam int N_COUNT        = 16;

  typedef struct packed {
    logic [N_COUNT-1:0]     connections;
    logic [V_PRECISION-1:0] vthresh;
    logic [V_PRECISION-1:0] A;
    logic [V_PRECISION-1:0] B;
    logic [V_PRECISION-1:0] C;
    logic [V_PRECISION-1:0] membrane_potential;
  } sram_data_t;
endpackage

module neuron_sram
  import data_types::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rd_en,
  input  logic [SRAM_ADDR_SIZE-1:0] sram_addr,
  output logic                      sram_resp,
  output sram_data_t                sram_rd,
  input  logic                      pot_we,
  input  logic [SRAM_ADDR_SIZE-1:0] pot_addr,
  input  logic [V_PRECISION-1:0]    pot_data,
  input  logic                      cfg_we,
  input  logic [SRAM_ADDR_SIZE-1:0] cfg_addr,
  input  sram_data_t                cfg_data,
  output logic                      busy
);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
      $error("neuron_sram: RD_LATENCY must be in 1..15");
    end
  endgenerate

  localparam int DEPTH = 2 ** SRAM_ADDR_SIZE;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [SRAM_ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                      sram_resp_q, busy_q;
  sram_data_t                sram_rd_q;
  sram_data_t                rd_fetch;
  logic                      load_rd;
  logic                      pot_shadowed;

  sram_data_t mem [DEPTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      IDLE: begin
        if (rd_en) begin
          rd_addr_d = sram_addr;
          cnt_d     = 4'(RD_LATENCY - 1);
          state_d   = (RD_LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rd_addr_d (not _q) so that RD_LATENCY=1 reads the address latched on this same edge
  always_comb begin
    rd_fetch = mem[rd_addr_d];
`ifdef NEURON_SRAM_WR_FWD_EN
    if (pot_we && pot_addr == rd_addr_d) rd_fetch.membrane_potential = pot_data;
    if (cfg_we && cfg_addr == rd_addr_d) rd_fetch = cfg_data;
`endif
  end

  assign load_rd      = (state_d == RESP) && (state_q != RESP);
  assign pot_shadowed = cfg_we && (cfg_addr == pot_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_addr_q   <= '0;
      sram_resp_q <= 1'b0;
      busy_q      <= 1'b0;
      sram_rd_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_addr_q   <= rd_addr_d;
      sram_resp_q <= (state_d == RESP);
      busy_q      <= (state_d != IDLE);
      if (load_rd) sram_rd_q <= rd_fetch;
    end
  end

  // Memory survives reset; a config write to the same address shadows the potential writeback
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (pot_we && !pot_shadowed) mem[pot_addr].membrane_potential <= pot_data;
      if (cfg_we) mem[cfg_addr] <= cfg_data;
    end
  end

  assign sram_resp = sram_resp_q;
  assign sram_rd   = sram_rd_q;
  assign busy      = busy_q;

endmodule
